// File: rtl/hazard_controller.sv
// Pipeline hazard controller: branch flush, multi-cycle muldiv stall, load-use
// interlock and halt, with a saturating count of stalled cycles.
//
// state  | meaning
// RUN    | normal issue; one action per cycle by priority branch > muldiv > load-use > halt
// MULDIV | multiply/divide occupying EX; cnt counts remaining stall cycles down to 0
// HALT   | pipeline frozen until reset
module hazard_controller #(
    parameter int         MULDIV_CYCLES = 4,
    parameter logic [3:0] HALT_OPCODE   = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_op1,
    input  logic [3:0]  id_op2,
    input  logic        id_uses_op2,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_write_reg,
    input  logic        ex_branch_taken,
    input  logic        ex_muldiv_start,
    output logic        pc_stop,
    output logic        if_pc_mux,
    output logic        if_id_buffer_hold,
    output logic        if_id_buffer_flush,
    output logic        id_ex_buffer_hold,
    output logic        id_ex_buffer_flush,
    output logic        ex_mem_buffer_flush,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    typedef enum logic [1:0] {RUN, MULDIV, HALT} state_t;

    localparam logic [3:0] CNT_INIT = 4'(MULDIV_CYCLES - 2);

    state_t     state, next_state;
    logic [3:0] cnt, next_cnt;
    logic       load_use;

    assign load_use = ex_mem_read &&
                      ((id_op1 == ex_write_reg) || (id_uses_op2 && (id_op2 == ex_write_reg)));

    always_comb begin
        next_state          = state;
        next_cnt            = cnt;
        pc_stop             = 1'b0;
        if_pc_mux           = 1'b0;
        if_id_buffer_hold   = 1'b0;
        if_id_buffer_flush  = 1'b0;
        id_ex_buffer_hold   = 1'b0;
        id_ex_buffer_flush  = 1'b0;
        ex_mem_buffer_flush = 1'b0;
        case (state)
            RUN: begin
                if (ex_branch_taken) begin
                    if_pc_mux          = 1'b1;
                    if_id_buffer_flush = 1'b1;
                    id_ex_buffer_flush = 1'b1;
                end else if (ex_muldiv_start) begin
                    pc_stop             = 1'b1;
                    if_id_buffer_hold   = 1'b1;
                    id_ex_buffer_hold   = 1'b1;
                    ex_mem_buffer_flush = 1'b1;
                    next_state          = MULDIV;
                    next_cnt            = CNT_INIT;
                end else if (load_use) begin
                    pc_stop            = 1'b1;
                    if_id_buffer_hold  = 1'b1;
                    id_ex_buffer_flush = 1'b1;
                end else if (id_opcode == HALT_OPCODE) begin
                    pc_stop            = 1'b1;
                    if_id_buffer_hold  = 1'b1;
                    id_ex_buffer_flush = 1'b1;
                    next_state         = HALT;
                end
            end
            MULDIV: begin
                // cnt==0 is the final EX cycle: result leaves EX, no stall
                if (cnt != 4'd0) begin
                    pc_stop             = 1'b1;
                    if_id_buffer_hold   = 1'b1;
                    id_ex_buffer_hold   = 1'b1;
                    ex_mem_buffer_flush = 1'b1;
                    next_cnt            = cnt - 4'd1;
                end else begin
                    next_state = RUN;
                end
            end
            HALT: begin
                pc_stop            = 1'b1;
                if_id_buffer_hold  = 1'b1;
                id_ex_buffer_flush = 1'b1;
            end
            default: begin
                next_state = RUN;
                next_cnt   = 4'd0;
            end
        endcase
        if (reset) begin
            next_state          = RUN;
            next_cnt            = 4'd0;
            pc_stop             = 1'b0;
            if_pc_mux           = 1'b0;
            if_id_buffer_hold   = 1'b0;
            if_id_buffer_flush  = 1'b0;
            id_ex_buffer_hold   = 1'b0;
            id_ex_buffer_flush  = 1'b0;
            ex_mem_buffer_flush = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= RUN;
            cnt          <= 4'd0;
            halted       <= 1'b0;
            stall_cycles <= 16'd0;
        end else begin
            state  <= next_state;
            cnt    <= next_cnt;
            halted <= (next_state == HALT);
            if (pc_stop && (state != HALT) && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Scoreboard bench for hazard_controller: each applied vector queues its
// expected outputs, which are compared on the following falling edge.
module tb_hazard_controller;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  id_opcode = 4'h0, id_op1 = 4'h1, id_op2 = 4'h2, ex_write_reg = 4'h0;
    logic        id_uses_op2 = 1'b0, ex_mem_read = 1'b0;
    logic        ex_branch_taken = 1'b0, ex_muldiv_start = 1'b0;
    logic        pc_stop, if_pc_mux, if_id_buffer_hold, if_id_buffer_flush;
    logic        id_ex_buffer_hold, id_ex_buffer_flush, ex_mem_buffer_flush, halted;
    logic [15:0] stall_cycles;

    // ctrl = {pc_stop, if_pc_mux, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_BR   = 7'b0101010;
    localparam logic [6:0] C_MD   = 7'b1010101;
    localparam logic [6:0] C_LU   = 7'b1010010;

    typedef struct packed {
        int          idx;
        logic [6:0]  ctrl;
        logic        halted;
        logic [15:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   vec_idx = 0;

    hazard_controller dut (
        .clock(clock), .reset(reset),
        .id_opcode(id_opcode), .id_op1(id_op1), .id_op2(id_op2), .id_uses_op2(id_uses_op2),
        .ex_mem_read(ex_mem_read), .ex_write_reg(ex_write_reg),
        .ex_branch_taken(ex_branch_taken), .ex_muldiv_start(ex_muldiv_start),
        .pc_stop(pc_stop), .if_pc_mux(if_pc_mux),
        .if_id_buffer_hold(if_id_buffer_hold), .if_id_buffer_flush(if_id_buffer_flush),
        .id_ex_buffer_hold(id_ex_buffer_hold), .id_ex_buffer_flush(id_ex_buffer_flush),
        .ex_mem_buffer_flush(ex_mem_buffer_flush), .halted(halted), .stall_cycles(stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL %s vec %0d: got %0h expected %0h", tag, idx, obs, expv);
        end
    endtask

    task automatic drive(input logic rst, input logic [3:0] opc, input logic [3:0] op1,
                         input logic [3:0] op2, input logic u2, input logic mr,
                         input logic [3:0] wr, input logic br, input logic md);
        @(posedge clock);
        #1;
        reset           = rst;
        id_opcode       = opc;
        id_op1          = op1;
        id_op2          = op2;
        id_uses_op2     = u2;
        ex_mem_read     = mr;
        ex_write_reg    = wr;
        ex_branch_taken = br;
        ex_muldiv_start = md;
    endtask

    task automatic apply(input logic rst, input logic [3:0] opc, input logic [3:0] op1,
                         input logic [3:0] op2, input logic u2, input logic mr,
                         input logic [3:0] wr, input logic br, input logic md,
                         input logic [6:0] e_ctrl, input logic e_halt, input logic [15:0] e_stall);
        exp_t e;
        drive(rst, opc, op1, op2, u2, mr, wr, br, md);
        vec_idx++;
        e.idx    = vec_idx;
        e.ctrl   = e_ctrl;
        e.halted = e_halt;
        e.stall  = e_stall;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic [6:0] e_ctrl, input logic e_halt, input logic [15:0] e_stall);
        apply(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, e_ctrl, e_halt, e_stall);
    endtask

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("ctrl", e.idx, 32'({pc_stop, if_pc_mux, if_id_buffer_hold, if_id_buffer_flush,
                                      id_ex_buffer_hold, id_ex_buffer_flush, ex_mem_buffer_flush}),
                  32'(e.ctrl));
            check("halted", e.idx, 32'(halted), 32'(e.halted));
            check("stall_cycles", e.idx, 32'(stall_cycles), 32'(e.stall));
        end
    end

    initial begin
        // reset overrides any hazard inputs
        apply(1'b1, 4'hF, 4'h3, 4'h3, 1'b1, 1'b1, 4'h3, 1'b1, 1'b1, C_NONE, 1'b0, 16'd0);
        idle(C_NONE, 1'b0, 16'd0);
        // load-use on op1, op2 with/without id_uses_op2, and R0
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, C_LU,   1'b0, 16'd0);
        idle(C_NONE, 1'b0, 16'd1);
        apply(1'b0, 4'h0, 4'h1, 4'h5, 1'b0, 1'b1, 4'h5, 1'b0, 1'b0, C_NONE, 1'b0, 16'd1);
        apply(1'b0, 4'h0, 4'h1, 4'h5, 1'b1, 1'b1, 4'h5, 1'b0, 1'b0, C_LU,   1'b0, 16'd1);
        apply(1'b0, 4'h0, 4'h0, 4'h2, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, C_LU,   1'b0, 16'd2);
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b0, 4'h3, 1'b0, 1'b0, C_NONE, 1'b0, 16'd3);
        // muldiv: 3 stall cycles, branch ignored at cnt=1, restart ignored at cnt=0
        apply(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, C_MD,   1'b0, 16'd3);
        idle(C_MD, 1'b0, 16'd4);
        apply(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, C_MD,   1'b0, 16'd5);
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, C_NONE, 1'b0, 16'd6);
        idle(C_NONE, 1'b0, 16'd6);
        // branch outranks muldiv and load-use; no MULDIV entry afterwards
        apply(1'b0, 4'hF, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b1, 1'b1, C_BR,   1'b0, 16'd6);
        idle(C_NONE, 1'b0, 16'd6);
        // reset mid-MULDIV aborts it
        apply(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, C_MD,   1'b0, 16'd6);
        idle(C_MD, 1'b0, 16'd7);
        apply(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, C_NONE, 1'b0, 16'd0);
        idle(C_NONE, 1'b0, 16'd0);
        // halt: counted once on entry, then frozen for 100 cycles; branch ignored
        apply(1'b0, 4'hF, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, C_LU,   1'b0, 16'd0);
        for (int i = 0; i < 100; i++)
            apply(1'b0, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'(i % 2), 1'b0, C_LU, 1'b1, 16'd1);
        apply(1'b1, 4'h0, 4'h1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, C_NONE, 1'b0, 16'd0);
        idle(C_NONE, 1'b0, 16'd0);
        // load-use outranks halt opcode
        apply(1'b0, 4'hF, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, C_LU,   1'b0, 16'd0);
        idle(C_NONE, 1'b0, 16'd1);
        // saturation over ~70000 load-use stalls
        for (int i = 0; i < 65533; i++)
            drive(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, C_LU, 1'b0, 16'd65534);
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, C_LU, 1'b0, 16'hFFFF);
        for (int i = 0; i < 4470; i++)
            drive(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0);
        apply(1'b0, 4'h0, 4'h3, 4'h2, 1'b0, 1'b1, 4'h3, 1'b0, 1'b0, C_LU, 1'b0, 16'hFFFF);
        idle(C_NONE, 1'b0, 16'hFFFF);
        repeat (2) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hazard_controller.md
HAZARD_CONTROLLER -- requirements
Module: hazard_controller

Interface
REQ-001 The block SHALL be built with one clock; reset is asynchronous and active-high; the ports SHALL be named clock and reset.
REQ-002 The block SHALL have parameter MULDIV_CYCLES, default 4, total EX-stage cycles of a multiply/divide; legal values are 2..15.
REQ-003 The block SHALL have parameter HALT_OPCODE, default 4'hF, the opcode that halts the pipeline.
REQ-004 clock  in  1  pipeline clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high; clears all state.
REQ-006 id_opcode  in  4  opcode of the instruction in ID.
REQ-007 id_op1  in  4  ID first source register number.
REQ-008 id_op2  in  4  ID second source register number.
REQ-009 id_uses_op2  in  1  ID instruction reads op2.
REQ-010 ex_mem_read  in  1  EX instruction is a load.
REQ-011 ex_write_reg  in  4  EX destination register number.
REQ-012 ex_branch_taken  in  1  EX branch/jump resolved taken.
REQ-013 ex_muldiv_start  in  1  EX holds a multiply/divide (first EX cycle).
REQ-014 pc_stop  out  1  freeze the program counter.
REQ-015 if_pc_mux  out  1  select branch target into the PC.
REQ-016 if_id_buffer_hold, if_id_buffer_flush  out  1 each  IF/ID hold and bubble.
REQ-017 id_ex_buffer_hold, id_ex_buffer_flush  out  1 each  ID/EX hold and bubble.
REQ-018 ex_mem_buffer_flush  out  1  insert a bubble into EX/MEM.
REQ-019 halted  out  1  registered; pipeline halted.
REQ-020 stall_cycles  out  16  registered count of stalled cycles.

Function
REQ-021 The control outputs (REQ-014..018) SHALL be combinational from the state and the current inputs; halted and stall_cycles SHALL be registered.
REQ-022 The FSM SHALL have three states: RUN, MULDIV and HALT, with a 4-bit down-counter cnt.
REQ-023 In RUN, exactly one action SHALL be taken, in this priority order: branch, muldiv, load-use, halt, none.
REQ-024 Branch (ex_branch_taken=1): the block SHALL assert if_pc_mux, if_id_buffer_flush and id_ex_buffer_flush for that cycle, with no stall; the state stays RUN.
REQ-025 Muldiv (ex_muldiv_start=1): the block SHALL assert pc_stop, if_id_buffer_hold, id_ex_buffer_hold and ex_mem_buffer_flush; next state is MULDIV with cnt=MULDIV_CYCLES-2.
REQ-026 Load-use (ex_mem_read=1 and (id_op1==ex_write_reg or (id_uses_op2=1 and id_op2==ex_write_reg))): the block SHALL assert pc_stop, if_id_buffer_hold and id_ex_buffer_flush for one cycle; R0 is not excluded; the state stays RUN.
REQ-027 Halt (id_opcode==HALT_OPCODE): the block SHALL assert pc_stop, if_id_buffer_hold and id_ex_buffer_flush; next state is HALT.
REQ-028 In MULDIV with cnt!=0, the block SHALL assert the muldiv stall set of REQ-025 and decrement cnt; ex_muldiv_start, ex_branch_taken and the load-use condition SHALL be ignored.
REQ-029 In MULDIV with cnt==0, the block SHALL assert no control outputs and return to RUN; total EX occupancy is MULDIV_CYCLES cycles, of which MULDIV_CYCLES-1 are stall cycles.
REQ-030 In HALT, the block SHALL assert pc_stop, if_id_buffer_hold and id_ex_buffer_flush every cycle and set halted=1 from the first HALT cycle; HALT is exited only by reset.
REQ-031 stall_cycles SHALL increment on each clock edge where pc_stop=1 and state!=HALT, and SHALL saturate at 16'hFFFF.
REQ-032 hold and flush of the same buffer SHALL never be asserted together.

Reset
REQ-033 While reset=1, the block SHALL force state=RUN, cnt=0, halted=0 and stall_cycles=0, and force all control outputs to 0.
REQ-034 A reset asserted mid-MULDIV or during HALT SHALL abort the operation immediately; the first cycle after release is RUN.

Verification
REQ-035 Load-use: ex_mem_read=1, ex_write_reg=3, id_op1=3 -> exactly one cycle of pc_stop=1, if_id_buffer_hold=1, id_ex_buffer_flush=1; stall_cycles goes 0 to 1.
REQ-036 Muldiv with default parameters: pulse ex_muldiv_start -> three consecutive stall cycles, then one clean cycle, then RUN; stall_cycles=3.
REQ-037 Priority: ex_branch_taken=1 together with ex_muldiv_start=1 and a load-use match -> only if_pc_mux=1, if_id_buffer_flush=1, id_ex_buffer_flush=1; no stall.
REQ-038 Branch asserted during MULDIV with cnt=1 -> ignored; the stall continues.
REQ-039 Halt: id_opcode=4'hF -> halted=1 on the next edge, pc_stop held for 100 cycles, stall_cycles frozen; reset -> all outputs 0.
REQ-040 Saturation: force 70000 load-use stalls -> stall_cycles=16'hFFFF, with no wrap to 0.
